edge_frame_writer: RTL and testbench
====================================

EDGE_FRAME_WRITER -- requirements
Module: edge_frame_writer

Interface
REQ-001 The block SHALL have parameters: H_ACTIVE, default 640, pixels per line; V_ACTIVE, default 480, lines per frame; ADDR_W, default 19, width of the per-bank linear address.
REQ-002 The block SHALL have port video_clk  input  1  the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port pix_valid  input  1  an upstream edge-classifier pixel is present.
REQ-005 The block SHALL have port pix_class  input  3  edge class code (0 = none, 1..4 = edge classes).
REQ-006 The block SHALL have port pix_sof  input  1  first pixel of a frame; meaningful only when pix_valid=1.
REQ-007 The block SHALL have port pix_ready  output  1  block accepts a pixel this cycle; transfer = pix_valid & pix_ready.
REQ-008 The block SHALL have port disp_vsync  input  1  active-low vsync from the display stage.
REQ-009 The block SHALL have port wr_en  output  1  frame-buffer write strobe.
REQ-010 The block SHALL have port wr_addr  output  ADDR_W+1  {bank, linear address}.
REQ-011 The block SHALL have port wr_data  output  3  class code written.
REQ-012 The block SHALL have port rd_bank  output  1  bank the display stage reads.
REQ-013 The block SHALL have port frame_done  output  1  one-cycle pulse when a full frame is written.
REQ-014 The block SHALL have port err_short  output  1  one-cycle pulse when a frame is aborted by an early pix_sof.

Function
REQ-015 The block SHALL implement states IDLE (wait for sof), WRITE (fill frame), HOLD (frame complete, wait for swap).
REQ-016 pix_ready SHALL be 1 in IDLE and WRITE and 0 in HOLD; it is a combinational function of state only.
REQ-017 In IDLE, accepted pixels with pix_sof=0 SHALL be consumed and discarded (no write).
REQ-018 In IDLE, an accepted pixel with pix_sof=1 SHALL be written at linear address 0, set x=1, y=0, and move to WRITE.
REQ-019 In WRITE, each accepted pixel SHALL be written at the current linear address; x increments, and at x=H_ACTIVE-1 wraps to 0 with y incremented.
REQ-020 The linear address SHALL be maintained incrementally (+1 per accepted pixel, reset to 0 on sof) with no multiplier; it equals y*H_ACTIVE+x.
REQ-021 wr_en, wr_addr and wr_data SHALL be registered: they assert exactly one cycle after the accepting edge, with wr_addr[ADDR_W] = current write bank.
REQ-022 Accepting the pixel at x=H_ACTIVE-1, y=V_ACTIVE-1 SHALL move to HOLD and pulse frame_done in the same cycle its wr_en asserts.
REQ-023 In WRITE, an accepted pixel with pix_sof=1 SHALL pulse err_short, be written at address 0, and restart counting from x=1, y=0; state stays WRITE.
REQ-024 Cycles with pix_valid=0 SHALL hold all counters and produce wr_en=0.
REQ-025 disp_vsync SHALL be registered once; a falling edge is previous=1 and current=0.
REQ-026 In HOLD, on a vsync falling edge the block SHALL set rd_bank to the bank just written, toggle the write bank, and go to IDLE, all in one cycle.
REQ-027 Vsync falling edges in IDLE or WRITE SHALL be ignored; rd_bank changes only per REQ-026.
REQ-028 rd_bank and the write bank SHALL always differ.

Reset
REQ-029 On reset the block SHALL set: state=IDLE; x=y=linear address=0; write bank=1; rd_bank=0; wr_en=0; wr_addr=0; wr_data=0; frame_done=0; err_short=0; registered vsync=1.
REQ-030 Reset asserted mid-frame SHALL abandon the partial frame with no further writes and no done/err pulses; the next frame starts only on a new pix_sof.

Verification
REQ-031 Reset, then a full 640x480 frame streamed with pix_valid=1 continuously -> 307200 writes at addresses {1,0..307199}, frame_done pulses once with the write at {1,307199}, pix_ready drops to 0.
REQ-032 After REQ-031, drive disp_vsync 1->0 -> two cycles later rd_bank=1 and pix_ready=1; the next frame writes to bank 0.
REQ-033 Send 5 pixels without sof, then sof with class 3 -> no writes for the first 5; one write {1,0} with data 3.
REQ-034 Send sof, 1000 pixels, then sof again -> err_short pulses once; the next write is at {1,0}; frame_done only after a further 307199 pixels.
REQ-035 Randomly toggle pix_valid over a frame -> write count and address sequence are identical to REQ-031, and wr_en=0 in every idle cycle.
REQ-036 Assert reset at pixel 50000 -> the next cycle has wr_en=0, rd_bank=0, and state IDLE; pixels without sof are then discarded.

Source files
------------

// File: rtl/edge_frame_writer.sv
// Edge-class frame writer: places classified pixels into a double-buffered frame
// store. A completed frame is held until display vsync swaps the read and write banks.
module edge_frame_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              video_clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [2:0]        pix_class,
  input  logic              pix_sof,
  output logic              pix_ready,
  input  logic              disp_vsync,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [2:0]        wr_data,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              err_short,
  output logic [1:0]        fsm_state
);

  // Handshake: a pixel transfers on a rising edge where pix_valid & pix_ready.
  // pix_ready depends on state only, so it never depends on pix_valid.

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [XW-1:0]     x, x_nx;
  logic [YW-1:0]     y, y_nx;
  logic [ADDR_W-1:0] lin, lin_nx, wr_lin;
  logic              wr_bank, wr_bank_nx, rd_bank_nx;
  logic              vsync_q, vsync_fall;
  logic              accept, write_go, done_go, err_go;

  assign pix_ready  = (state != HOLD);
  assign accept     = pix_valid & pix_ready;
  assign vsync_fall = vsync_q & ~disp_vsync;
  assign fsm_state  = state;

  always_comb begin
    state_nx   = state;
    x_nx       = x;
    y_nx       = y;
    lin_nx     = lin;
    wr_bank_nx = wr_bank;
    rd_bank_nx = rd_bank;
    wr_lin     = lin;
    write_go   = 1'b0;
    done_go    = 1'b0;
    err_go     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && pix_sof) begin
          write_go = 1'b1;
          wr_lin   = '0;
          x_nx     = XW'(1);
          y_nx     = '0;
          lin_nx   = ADDR_W'(1);
          state_nx = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          write_go = 1'b1;
          if (pix_sof) begin
            // Early sof: drop the partial frame and restart at the origin.
            err_go = 1'b1;
            wr_lin = '0;
            x_nx   = XW'(1);
            y_nx   = '0;
            lin_nx = ADDR_W'(1);
          end else if (x == X_LAST && y == Y_LAST) begin
            done_go  = 1'b1;
            state_nx = HOLD;
            x_nx     = '0;
            y_nx     = '0;
            lin_nx   = '0;
          end else if (x == X_LAST) begin
            x_nx   = '0;
            y_nx   = y + YW'(1);
            lin_nx = lin + ADDR_W'(1);
          end else begin
            x_nx   = x + XW'(1);
            lin_nx = lin + ADDR_W'(1);
          end
        end
      end
      HOLD: begin
        if (vsync_fall) begin
          rd_bank_nx = wr_bank;
          wr_bank_nx = ~wr_bank;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge video_clk) begin
    if (reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      lin        <= '0;
      wr_bank    <= 1'b1;
      rd_bank    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      vsync_q    <= 1'b1;
    end else begin
      state      <= state_nx;
      x          <= x_nx;
      y          <= y_nx;
      lin        <= lin_nx;
      wr_bank    <= wr_bank_nx;
      rd_bank    <= rd_bank_nx;
      wr_en      <= write_go;
      frame_done <= done_go;
      err_short  <= err_go;
      vsync_q    <= disp_vsync;
      if (write_go) begin
        wr_addr <= {wr_bank, wr_lin};
        wr_data <= pix_class;
      end
    end
  end

endmodule

// File: tb/tb_edge_frame_writer.sv
// Bench for edge_frame_writer on a small 8x4 frame: a reset/IDLE vector table,
// then model-driven frames checked cycle by cycle through an expected queue.
module tb_edge_frame_writer;

  localparam int H = 8;
  localparam int V = 4;
  localparam int AW = 5;
  localparam int FRAME = H * V;

  logic          video_clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_valid = 1'b0;
  logic [2:0]    pix_class = '0;
  logic          pix_sof = 1'b0;
  logic          disp_vsync = 1'b1;
  logic          pix_ready, wr_en, rd_bank, frame_done, err_short;
  logic [AW:0]   wr_addr;
  logic [2:0]    wr_data;
  logic [1:0]    fsm_state;

  always #5 video_clk = ~video_clk;

  edge_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .video_clk(video_clk), .reset(reset), .pix_valid(pix_valid),
    .pix_class(pix_class), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .disp_vsync(disp_vsync), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_bank(rd_bank), .frame_done(frame_done),
    .err_short(err_short), .fsm_state(fsm_state)
  );

  typedef struct packed {
    logic        wr_en;
    logic        done;
    logic        err;
    logic [AW:0] addr;
    logic [2:0]  data;
    logic        rd_bank;
    logic        ready;
  } exp_t;

  typedef struct {
    logic        v;
    logic        s;
    logic [2:0]  c;
    logic        exp_wr;
    logic [AW:0] exp_addr;
    logic [2:0]  exp_data;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[10];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_writes = 0;

  // Reference model state: 0 idle, 1 writing, 2 holding.
  int   m_state = 0;
  int   m_addr = 0;
  logic m_wbank = 1'b1;
  logic m_rbank = 1'b0;
  logic m_vs_q = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_out();
    exp_t e, a;
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    a = '0;
    a.wr_en   = wr_en;
    a.done    = frame_done;
    a.err     = err_short;
    a.addr    = e.wr_en ? wr_addr : '0;
    a.data    = e.wr_en ? wr_data : '0;
    a.rd_bank = rd_bank;
    a.ready   = pix_ready;
    check("cycle{wr_en,done,err,addr,data,rd_bank,ready}", 32'(a), 32'(e));
  endtask

  task automatic step(input logic v, input logic s, input logic [2:0] c, input logic vs);
    exp_t e;
    logic acc, fall;
    pix_valid  = v;
    pix_sof    = s;
    pix_class  = c;
    disp_vsync = vs;
    e    = '0;
    acc  = v && (m_state != 2);
    fall = m_vs_q && !vs;
    if (acc) begin
      if (m_state == 0) begin
        if (s) begin
          e.wr_en = 1'b1; e.addr = {m_wbank, AW'(0)}; e.data = c;
          m_addr = 1; m_state = 1;
        end
      end else begin
        e.wr_en = 1'b1; e.data = c;
        if (s) begin
          e.err = 1'b1; e.addr = {m_wbank, AW'(0)}; m_addr = 1;
        end else begin
          e.addr = {m_wbank, AW'(m_addr)};
          if (m_addr == FRAME - 1) begin
            e.done = 1'b1; m_state = 2; m_addr = 0;
          end else begin
            m_addr++;
          end
        end
      end
    end else if (m_state == 2 && fall) begin
      m_rbank = m_wbank;
      m_wbank = ~m_wbank;
      m_state = 0;
    end
    m_vs_q    = vs;
    e.rd_bank = m_rbank;
    e.ready   = (m_state != 2);
    if (e.wr_en) n_writes++;
    exp_q.push_back(e);
    @(posedge video_clk); #1;
    compare_out();
  endtask

  task automatic do_reset();
    reset = 1'b1; pix_valid = 1'b1; pix_sof = 1'b0; disp_vsync = 1'b1;
    @(posedge video_clk); #1;
    reset = 1'b0;
    m_state = 0; m_addr = 0; m_wbank = 1'b1; m_rbank = 1'b0; m_vs_q = 1'b1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_done_err", {frame_done, err_short}, 0);
    check("rst_state_idle", fsm_state, 0);
    check("rst_pix_ready", pix_ready, 1);
  endtask

  task automatic swap_banks();
    step(1'b0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  initial begin
    int w0;
    // IDLE discard, sof, then WRITE with a valid gap.
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b0, 3'(i), 1'b0, '0, '0};
    tbl[5] = '{1'b0, 1'b1, 3'd4, 1'b0, '0, '0};
    tbl[6] = '{1'b1, 1'b1, 3'd3, 1'b1, {1'b1, 5'd0}, 3'd3};
    tbl[7] = '{1'b1, 1'b0, 3'd1, 1'b1, {1'b1, 5'd1}, 3'd1};
    tbl[8] = '{1'b0, 1'b0, 3'd7, 1'b0, '0, '0};
    tbl[9] = '{1'b1, 1'b0, 3'd2, 1'b1, {1'b1, 5'd2}, 3'd2};

    @(posedge video_clk); #1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pix_valid = tbl[i].v; pix_sof = tbl[i].s; pix_class = tbl[i].c; disp_vsync = 1'b1;
      @(posedge video_clk); #1;
      check($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].exp_wr);
      if (tbl[i].exp_wr) begin
        check($sformatf("tbl%0d_addr", i), wr_addr, tbl[i].exp_addr);
        check($sformatf("tbl%0d_data", i), wr_data, tbl[i].exp_data);
      end
    end

    // Full continuous frame into bank 1, then stall in HOLD.
    do_reset();
    w0 = n_writes;
    for (int i = 0; i < FRAME; i++) step(1'b1, i == 0, 3'($urandom_range(0, 4)), 1'b1);
    check("frame1_writes", n_writes - w0, FRAME);
    check("hold_state", fsm_state, 2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd1, 1'b1);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 1'b0);
    check("swap_rd_bank", rd_bank, 1);
    check("swap_pix_ready", pix_ready, 1);
    step(1'b0, 1'b0, 3'd0, 1'b1);

    // Frame into bank 0 with random valid gaps; bounded run.
    w0 = n_writes;
    step(1'b1, 1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 1000 && m_state != 2; i++)
      step(1'($urandom_range(0, 1)), 1'b0, 3'($urandom_range(0, 4)), 1'b1);
    check("frame2_writes", n_writes - w0, FRAME);
    check("frame2_hold", fsm_state, 2);
    swap_banks();

    // Early sof after 10 pixels; vsync toggling during WRITE is ignored.
    step(1'b1, 1'b1, 3'd1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 3'd2, 1'(i % 2));
    step(1'b1, 1'b1, 3'd4, 1'b1);
    for (int i = 0; i < FRAME - 1; i++) step(1'b1, 1'b0, 3'd3, 1'(i % 2));
    check("short_frame_hold", fsm_state, 2);
    swap_banks();

    // Reset mid-frame, then sof-less pixels must be discarded.
    step(1'b1, 1'b1, 3'd1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 3'd2, 1'b1);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'd3, 1'b1);
    check("post_reset_idle", fsm_state, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
